sbox_arbiter: RTL and testbench

SBOX_ARBITER -- requirements
Module: sbox_arbiter

---
 rtl/sbox_arbiter.sv | 108 ++++++++++
 tb/tb_sbox_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_arbiter.sv
// Round-robin arbiter sharing one 4-lane S-box between key expansion (kx) and sub-bytes (sb).
// Optional sb burst lock enabled by defining SBOX_ARB_LOCK_EN.
module sbox_arbiter (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        kx_req,
  input  logic [31:0] kx_word,
  input  logic        sb_req,
  input  logic [31:0] sb_word,
  input  logic        sb_lock,
  output logic        kx_gnt,
  output logic        sb_gnt,
  output logic        kx_rvalid,
  output logic        sb_rvalid,
  output logic [31:0] rdata,
  output logic [31:0] sbox_in,
  output logic        sbox_valid,
  input  logic [31:0] sbox_out,
  output logic        busy
);

  logic        r_last_sb;
  logic        r_sbox_valid;
  logic        r_tag;
  logic        r_kx_rvalid;
  logic        r_sb_rvalid;
  logic [31:0] r_sbox_in;
  logic        w_locked;
  logic        w_kx_gnt;
  logic        w_sb_gnt;

`ifdef SBOX_ARB_LOCK_EN
  logic       r_locked;
  logic [1:0] r_lock_cnt;

  assign w_locked = r_locked;

  // The counter wraps to zero on the 4th locked grant, which is also when the lock drops.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_locked   <= 1'b0;
      r_lock_cnt <= 2'd0;
    end else if (w_sb_gnt) begin
      if (r_locked) begin
        r_lock_cnt <= r_lock_cnt + 2'd1;
        if (r_lock_cnt == 2'd3)
          r_locked <= 1'b0;
      end else if (sb_lock) begin
        r_locked   <= 1'b1;
        r_lock_cnt <= 2'd1;
      end
    end
  end
`else
  logic w_unused_lock;

  assign w_locked      = 1'b0;
  assign w_unused_lock = sb_lock;
`endif

  // Grants are gated by n_rst so nothing is granted while reset is held.
  always_comb begin
    w_kx_gnt = 1'b0;
    w_sb_gnt = 1'b0;
    if (n_rst) begin
      if (w_locked) begin
        w_sb_gnt = sb_req;
      end else if (kx_req && sb_req) begin
        w_kx_gnt = r_last_sb;
        w_sb_gnt = ~r_last_sb;
      end else begin
        w_kx_gnt = kx_req;
        w_sb_gnt = sb_req;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_last_sb    <= 1'b1;
      r_sbox_valid <= 1'b0;
      r_tag        <= 1'b0;
      r_kx_rvalid  <= 1'b0;
      r_sb_rvalid  <= 1'b0;
      r_sbox_in    <= 32'd0;
    end else begin
      r_sbox_valid <= w_kx_gnt | w_sb_gnt;
      if (w_kx_gnt || w_sb_gnt) begin
        r_sbox_in <= w_sb_gnt ? sb_word : kx_word;
        r_tag     <= w_sb_gnt;
        r_last_sb <= w_sb_gnt;
      end
      r_kx_rvalid <= r_sbox_valid & ~r_tag;
      r_sb_rvalid <= r_sbox_valid & r_tag;
    end
  end

  assign kx_gnt     = w_kx_gnt;
  assign sb_gnt     = w_sb_gnt;
  assign kx_rvalid  = r_kx_rvalid;
  assign sb_rvalid  = r_sb_rvalid;
  assign sbox_in    = r_sbox_in;
  assign sbox_valid = r_sbox_valid;
  // The S-box answers in the same cycle the result strobe is high, so rdata is passed through.
  assign rdata      = (r_kx_rvalid | r_sb_rvalid) ? sbox_out : 32'd0;
  assign busy       = r_sbox_valid | r_kx_rvalid | r_sb_rvalid | w_locked;

endmodule

// File: tb/tb_sbox_arbiter.sv
// Scoreboard bench for sbox_arbiter: reference arbiter model plus an AES S-box model for sbox_out.
// Honours SBOX_ARB_LOCK_EN when the same macro is given to the bench.
module tb_sbox_arbiter;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        kx_req = 1'b0;
  logic [31:0] kx_word = 32'd0;
  logic        sb_req = 1'b0;
  logic [31:0] sb_word = 32'd0;
  logic        sb_lock = 1'b0;
  logic        kx_gnt, sb_gnt, kx_rvalid, sb_rvalid, sbox_valid, busy;
  logic [31:0] rdata, sbox_in;
  logic [31:0] sbox_out = 32'd0;

  typedef struct {
    logic        isSb;
    logic [31:0] data;
    int          cycle;
  } sbEntry_t;

  sbEntry_t    scoreQ[$];
  sbEntry_t    monEntry;
  int          errors = 0;
  int          checks = 0;
  int          cycleCount = 0;

  logic        mLastSb;
  int          mLockLeft;
  logic        mPrev1, mPrev2;
  logic [31:0] mSboxIn;
  logic        obsKx, obsSb;
  logic        expKxLast, expSbLast;

  sbox_arbiter dut (
    .clk(clk), .n_rst(n_rst),
    .kx_req(kx_req), .kx_word(kx_word),
    .sb_req(sb_req), .sb_word(sb_word), .sb_lock(sb_lock),
    .kx_gnt(kx_gnt), .sb_gnt(sb_gnt),
    .kx_rvalid(kx_rvalid), .sb_rvalid(sb_rvalid),
    .rdata(rdata), .sbox_in(sbox_in), .sbox_valid(sbox_valid),
    .sbox_out(sbox_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic       hi;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = x << 1;
      if (hi) x = x ^ 8'h1b;
      y = y >> 1;
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
  function automatic logic [7:0] sbox8(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(x, 8'(i)) == 8'h01) b = 8'(i);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sboxWord(input logic [31:0] w);
    return {sbox8(w[31:24]), sbox8(w[23:16]), sbox8(w[15:8]), sbox8(w[7:0])};
  endfunction

  always @(posedge clk) cycleCount <= cycleCount + 1;
  always @(posedge clk) sbox_out <= sboxWord(sbox_in);

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  task automatic modelReset();
    mLastSb   = 1'b1;
    mLockLeft = 0;
    mPrev1    = 1'b0;
    mPrev2    = 1'b0;
    mSboxIn   = 32'd0;
    scoreQ.delete();
  endtask

  // Reference arbiter: compare this cycle's outputs, then advance the model by the expected grant.
  task automatic checkOutput();
    logic expKx, expSb;
    expKx = 1'b0;
    expSb = 1'b0;
    if (mLockLeft > 0) expSb = sb_req;
    else if (kx_req && sb_req) begin
      if (mLastSb) expKx = 1'b1;
      else expSb = 1'b1;
    end else begin
      expKx = kx_req;
      expSb = sb_req;
    end
    obsKx = kx_gnt;
    obsSb = sb_gnt;
    checkValue("grant{kx,sb}", {62'd0, kx_gnt, sb_gnt}, {62'd0, expKx, expSb});
    checkValue("sbox_valid", {63'd0, sbox_valid}, {63'd0, mPrev1});
    checkValue("sbox_in", {32'd0, sbox_in}, {32'd0, mSboxIn});
    checkValue("busy", {63'd0, busy}, {63'd0, (mPrev1 || mPrev2 || mLockLeft > 0)});
`ifdef SBOX_ARB_LOCK_EN
    if (expSb) begin
      if (mLockLeft > 0) mLockLeft--;
      else if (sb_lock) mLockLeft = 3;
    end
`endif
    if (expKx || expSb) begin
      mLastSb = expSb;
      mSboxIn = expSb ? sb_word : kx_word;
      scoreQ.push_back('{expSb, sboxWord(mSboxIn), cycleCount});
    end
    mPrev2    = mPrev1;
    mPrev1    = expKx || expSb;
    expKxLast = expKx;
    expSbLast = expSb;
  endtask

  task automatic applyStimulus(input logic kr, input logic [31:0] kw, input logic sr,
                               input logic [31:0] sw, input logic sl);
    @(posedge clk);
    #1;
    kx_req  = kr;
    kx_word = kw;
    sb_req  = sr;
    sb_word = sw;
    sb_lock = sl;
    @(negedge clk);
    checkOutput();
  endtask

  // Requests stay high through reset to prove grants are suppressed, then drop before release.
  task automatic applyReset();
    @(posedge clk);
    #1;
    n_rst  = 1'b0;
    kx_req = 1'b1;
    sb_req = 1'b1;
    modelReset();
    @(negedge clk);
    checkValue("reset flags", {58'd0, kx_gnt, sb_gnt, kx_rvalid, sb_rvalid, sbox_valid, busy}, 64'd0);
    checkValue("reset sbox_in", {32'd0, sbox_in}, 64'd0);
    checkValue("reset rdata", {32'd0, rdata}, 64'd0);
    kx_req  = 1'b0;
    sb_req  = 1'b0;
    sb_lock = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic expectRvalid(input string name, input logic isSb, input logic [31:0] data);
    checkValue(name, {30'd0, sb_rvalid, kx_rvalid, data == 32'd0 ? rdata : rdata},
               {30'd0, isSb, ~isSb, data});
  endtask

  // Monitor: every result strobe must match the oldest outstanding grant, two cycles after it.
  always @(negedge clk) begin
    if (n_rst && (kx_rvalid || sb_rvalid)) begin
      checks++;
      if (scoreQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected rvalid: kx=%0b sb=%0b rdata=0x%08h, none outstanding",
                 kx_rvalid, sb_rvalid, rdata);
      end else begin
        monEntry = scoreQ.pop_front();
        if ({sb_rvalid, kx_rvalid} !== {monEntry.isSb, ~monEntry.isSb} || rdata !== monEntry.data
            || cycleCount != monEntry.cycle + 2) begin
          errors++;
          $display("[TB] FAIL result: got sb=%0b kx=%0b rdata=0x%08h cycle %0d, expected sb=%0b rdata=0x%08h cycle %0d",
                   sb_rvalid, kx_rvalid, rdata, cycleCount, monEntry.isSb, monEntry.data,
                   monEntry.cycle + 2);
        end
      end
    end
  end

  initial begin
    logic        kxPend, sbPend;
    logic [31:0] kxW, sbW;
    logic [7:0]  gv;
    int          kxDuringLock, sbDuringLock;

    modelReset();
    applyReset();

    // Single kx request of word 0 -> 0x63636363 two cycles later.
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expectRvalid("kx word 0 result", 1'b0, 32'h63636363);

    // Both requesting for four cycles after reset -> kx, sb, kx, sb.
    applyReset();
    gv = 8'd0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, $urandom, 1'b1, $urandom, 1'b0);
      gv = {gv[5:0], obsKx, obsSb};
    end
    checkValue("alternation", {56'd0, gv}, {56'd0, 8'b10_01_10_01});
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // sb wins over a pending kx after a kx grant; results come back on consecutive cycles.
    applyReset();
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b1, 32'h53535353, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expectRvalid("sb 0x53 result", 1'b1, 32'hEDEDEDED);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expectRvalid("kx after sb result", 1'b0, 32'h63636363);

    // Lock burst with kx always requesting and an sb_req gap mid-burst.
    applyReset();
    applyStimulus(1'b1, $urandom, 1'b1, $urandom, 1'b1);
    applyStimulus(1'b1, $urandom, 1'b1, $urandom, 1'b1);
    kxDuringLock = 0;
    sbDuringLock = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, $urandom, (i != 1), $urandom, 1'b0);
      kxDuringLock += int'(obsKx);
      sbDuringLock += int'(obsSb);
    end
`ifdef SBOX_ARB_LOCK_EN
    checkValue("kx grants inside lock", 64'(kxDuringLock), 64'd0);
    checkValue("sb grants after lock entry", 64'(sbDuringLock), 64'd3);
`endif
    applyStimulus(1'b1, $urandom, 1'b1, $urandom, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

`ifndef SBOX_ARB_LOCK_EN
    // Without the lock feature, sb_lock has no effect on alternation.
    applyReset();
    gv = 8'd0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, $urandom, 1'b1, $urandom, 1'b1);
      gv = {gv[5:0], obsKx, obsSb};
    end
    checkValue("alternation with sb_lock", {56'd0, gv}, {56'd0, 8'b10_01_10_01});
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`endif

    // Reset with two words in flight: they must never return, and kx wins next contention.
    applyStimulus(1'b1, $urandom, 1'b1, $urandom, 1'b0);
    applyStimulus(1'b1, $urandom, 1'b1, $urandom, 1'b0);
    applyReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, $urandom, 1'b1, $urandom, 1'b0);
    checkValue("post-reset winner", {62'd0, obsKx, obsSb}, {62'd0, 2'b10});

    // Random traffic obeying the hold-until-granted protocol.
    kxPend = 1'b0;
    sbPend = 1'b0;
    kxW    = 32'd0;
    sbW    = 32'd0;
    for (int i = 0; i < 1500; i++) begin
      if (!kxPend && $urandom_range(0, 99) < 55) begin
        kxPend = 1'b1;
        kxW    = $urandom;
      end
      if (!sbPend && $urandom_range(0, 99) < 55) begin
        sbPend = 1'b1;
        sbW    = $urandom;
      end
      applyStimulus(kxPend, kxW, sbPend, sbW, ($urandom_range(0, 9) == 0));
      if (expKxLast) kxPend = 1'b0;
      if (expSbLast) sbPend = 1'b0;
    end

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkValue("outstanding results", 64'(scoreQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
